pci_simple_target: RTL and testbench

- Single-function PCI memory target that responds to master cycles on the shared FRAME_/IRDY_/TRDY_/DEVSEL_/AD/C_BE_ bus.
- Claims memory read and write cycles to a fixed address window backed by a DEPTH x 32-bit register file.
- Drives DEVSEL_, TRDY_ and AD on reads, with programmable DEVSEL latency and initial wait states.
- Sits on the bench bus opposite the master and under the bus protocol property checker; it must never cause a protocol check to fire.

---
 rtl/pci_simple_target.sv | 157 +++++++++++++++
 tb/tb_pci_simple_target.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pci_simple_target.sv
// Single-function PCI memory target: claims mem read/write cycles to a fixed
// window backed by a DEPTH x 32-bit register file, with programmable DEVSEL/TRDY timing.
module pci_simple_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DEVSEL_LAT  = 1,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        FRAME_,
    input  logic        IRDY_,
    input  logic [3:0]  C_BE_,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        TRDY_,
    output logic        DEVSEL_,
    output logic        busy
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned T_WR = DEVSEL_LAT + WAIT_STATES;
    localparam int unsigned T_RD = (T_WR < 2) ? 2 : T_WR;
    localparam logic [3:0]  LAT_C  = 4'(DEVSEL_LAT);
    localparam logic [3:0]  TWR_C  = 4'(T_WR);
    localparam logic [3:0]  TRD_C  = 4'(T_RD);

    typedef enum logic [1:0] {IDLE, IGNORE, DEVWAIT, DATA} state_t;

    state_t          state_q, state_d;
    logic            frame_prev_q;
    logic            wr_q, wr_d;
    logic [AW-1:0]   idx_q, idx_d, idx_inc;
    logic [3:0]      cnt_q, cnt_d;
    logic            trdy_q, trdy_d;
    logic            devsel_q, devsel_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic [31:0]     ad_out_q, ad_out_d;
    logic            mem_we;
    logic [31:0]     mem_q [DEPTH];
    logic            claim;
    logic            unused_ad_lsb;

    assign unused_ad_lsb = ^AD_in[1:0];
    assign idx_inc = idx_q + AW'(1);
    assign claim   = (C_BE_[3:1] == 3'b011) &&
                     (AD_in[31:AW+2] == BASE_ADDR[31:AW+2]);

    assign AD_out  = ad_out_q;
    assign AD_oe   = oe_q;
    assign TRDY_   = trdy_q;
    assign DEVSEL_ = devsel_q;
    assign busy    = busy_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        trdy_d   = trdy_q;
        devsel_d = devsel_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        ad_out_d = ad_out_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!FRAME_ && frame_prev_q) begin
                    idx_d = AD_in[AW+1:2];
                    wr_d  = C_BE_[0];
                    if (claim) begin
                        state_d = DEVWAIT;
                        busy_d  = 1'b1;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            IGNORE: begin
                if (FRAME_ && IRDY_) state_d = IDLE;
            end
            DEVWAIT: begin
                if (FRAME_ && IRDY_) begin
                    state_d  = IDLE;
                    trdy_d   = 1'b1;
                    devsel_d = 1'b1;
                    oe_d     = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    // cnt_q holds the index of the current edge after the address phase
                    if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                    if (cnt_q >= LAT_C) devsel_d = 1'b0;
                    oe_d = !wr_q;
                    if (cnt_q >= (wr_q ? TWR_C : TRD_C)) begin
                        trdy_d  = 1'b0;
                        state_d = DATA;
                        if (!wr_q) ad_out_d = mem_q[idx_q];
                    end
                end
            end
            DATA: begin
                if (!IRDY_) begin
                    idx_d  = idx_inc;
                    mem_we = wr_q;
                    if (FRAME_) begin
                        state_d  = IDLE;
                        trdy_d   = 1'b1;
                        devsel_d = 1'b1;
                        oe_d     = 1'b0;
                        busy_d   = 1'b0;
                    end else if (!wr_q) begin
                        ad_out_d = mem_q[idx_inc];
                    end
                end else if (FRAME_) begin
                    state_d  = IDLE;
                    trdy_d   = 1'b1;
                    devsel_d = 1'b1;
                    oe_d     = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        frame_prev_q <= FRAME_;
        if (!reset_) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            ad_out_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            trdy_q   <= trdy_d;
            devsel_q <= devsel_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            ad_out_q <= ad_out_d;
            if (mem_we) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (!C_BE_[b]) mem_q[idx_q][8*b +: 8] <= AD_in[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_pci_simple_target.sv
// Bench for pci_simple_target: two instances (default timing and DEVSEL_LAT=3/WAIT_STATES=2)
// driven by a behavioural master, with a memory model and a read-data scoreboard.
module tb_pci_simple_target;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_;
    logic        frame, irdy;
    logic [3:0]  cbe;
    logic [31:0] ad;
    int          sel;

    logic        frame_w [2];
    logic        irdy_w  [2];
    logic [31:0] ad_out_w [2];
    logic        ad_oe_w  [2];
    logic        trdy_w   [2];
    logic        devsel_w [2];
    logic        busy_w   [2];

    // Only the selected target sees master activity; the other sees an idle bus
    assign frame_w[0] = (sel == 0) ? frame : 1'b1;
    assign irdy_w[0]  = (sel == 0) ? irdy  : 1'b1;
    assign frame_w[1] = (sel == 1) ? frame : 1'b1;
    assign irdy_w[1]  = (sel == 1) ? irdy  : 1'b1;

    pci_simple_target u0 (
        .clk(clk), .reset_(reset_), .FRAME_(frame_w[0]), .IRDY_(irdy_w[0]),
        .C_BE_(cbe), .AD_in(ad), .AD_out(ad_out_w[0]), .AD_oe(ad_oe_w[0]),
        .TRDY_(trdy_w[0]), .DEVSEL_(devsel_w[0]), .busy(busy_w[0])
    );

    pci_simple_target #(.DEVSEL_LAT(3), .WAIT_STATES(2)) u1 (
        .clk(clk), .reset_(reset_), .FRAME_(frame_w[1]), .IRDY_(irdy_w[1]),
        .C_BE_(cbe), .AD_in(ad), .AD_out(ad_out_w[1]), .AD_oe(ad_oe_w[1]),
        .TRDY_(trdy_w[1]), .DEVSEL_(devsel_w[1]), .busy(busy_w[1])
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model [2][16];
    logic [31:0] sbq [$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [3:0]  be;
        logic        claim;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) model[s][i] = '0;
    endtask

    // One master transaction; read expectations must already be queued by the caller
    task automatic run_cycle(input int s, input logic [31:0] addr, input logic [3:0] cmd,
                             input logic [31:0] wdata, input logic [3:0] be, input int nb,
                             input int stall_beat, input int stall_len, input bit claim);
        int lat, ws, texp, k, beats, stall_left, first_dv, first_tr, idx;
        bit is_rd, pend;
        lat   = (s == 0) ? 1 : 3;
        ws    = (s == 0) ? 0 : 2;
        is_rd = (cmd == 4'b0110);
        texp  = lat + ws;
        if (is_rd && texp < 2) texp = 2;
        idx   = int'(addr[5:2]);

        sel = s; frame = 1'b0; irdy = 1'b1; ad = addr; cbe = cmd;
        step();
        check("busy_at_E0", busy_w[s], claim);

        frame = (nb == 1); irdy = 1'b0; cbe = be; ad = is_rd ? 32'h0 : wdata;
        beats = 0; stall_left = stall_len; first_dv = -1; first_tr = -1; pend = 0; k = 0;
        while (beats < nb && k < 40) begin
            step();
            k++;
            if (pend) begin
                ad   = is_rd ? 32'h0 : wdata + beats;
                pend = 0;
            end
            if (!claim) begin
                check("unclaimed_idle", {trdy_w[s], devsel_w[s], ad_oe_w[s], busy_w[s]}, 4'b1100);
                if (k == 4) break;
                continue;
            end
            if (first_dv < 0 && !devsel_w[s]) first_dv = k;
            if (first_tr < 0 && !trdy_w[s])   first_tr = k;
            if (is_rd && k == 1) check("rd_oe_at_E1", ad_oe_w[s], 1);
            if (!trdy_w[s]) begin
                check("trdy_needs_devsel", devsel_w[s], 0);
                if (is_rd) begin
                    check("trdy_needs_oe", ad_oe_w[s], 1);
                    check("rd_data", ad_out_w[s], (sbq.size() > 0) ? sbq[0] : 32'hxxxx_xxxx);
                end
                if (beats == stall_beat && stall_left > 0) begin
                    irdy = 1'b1;
                    stall_left--;
                end else begin
                    irdy = 1'b0;
                    if (is_rd) begin
                        if (sbq.size() > 0) void'(sbq.pop_front());
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (!be[b]) model[s][idx][8*b +: 8] = ad[8*b +: 8];
                    end
                    idx   = (idx + 1) % 16;
                    beats++;
                    frame = (beats == nb);
                    pend  = 1;
                end
            end
        end
        if (claim) begin
            if (beats < nb) begin
                n_chk++;
                $display("FAIL timeout: %0d of %0d beats done at sel %0d", beats, nb, s);
            end
            step();
            check("idle_after_last", {trdy_w[s], devsel_w[s], ad_oe_w[s], busy_w[s]}, 4'b1100);
            check("devsel_latency", first_dv, lat);
            check("trdy_latency", first_tr, texp);
        end
        frame = 1'b1; irdy = 1'b1; cbe = 4'h0; ad = '0;
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [15];
        vecs[0]  = '{32'h0000_1008, 4'b0111, 32'hDEAD_BEEF, 4'b0000, 1'b1, 32'h0};
        vecs[1]  = '{32'h0000_1008, 4'b0110, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_1008, 4'b0111, 32'h1122_3344, 4'b1010, 1'b1, 32'h0};
        vecs[3]  = '{32'h0000_1008, 4'b0110, 32'h0,         4'b0000, 1'b1, 32'hDE22_BE44};
        vecs[4]  = '{32'h0000_2000, 4'b0111, 32'hCAFE_F00D, 4'b0000, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_1000, 4'b0110, 32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[6]  = '{32'h0000_1008, 4'b0010, 32'h0,         4'b0000, 1'b0, 32'h0};
        vecs[7]  = '{32'h0000_1038, 4'b0111, 32'h0E0E_0E0E, 4'b0000, 1'b1, 32'h0};
        vecs[8]  = '{32'h0000_103C, 4'b0111, 32'h0F0F_0F0F, 4'b0000, 1'b1, 32'h0};
        vecs[9]  = '{32'h0000_1000, 4'b0111, 32'hA0A0_A0A0, 4'b0000, 1'b1, 32'h0};
        vecs[10] = '{32'h0000_1004, 4'b0111, 32'hB1B1_B1B1, 4'b0000, 1'b1, 32'h0};
        vecs[11] = '{32'h0000_1008, 4'b0111, 32'h7777_7777, 4'b1111, 1'b1, 32'h0};
        vecs[12] = '{32'h0000_1008, 4'b0110, 32'h0,         4'b0000, 1'b1, 32'hDE22_BE44};
        vecs[13] = '{32'h0000_1040, 4'b0110, 32'h0,         4'b0000, 1'b0, 32'h0};
        vecs[14] = '{32'h0000_0FFC, 4'b0111, 32'h5555_AAAA, 4'b0000, 1'b0, 32'h0};

        clear_models();
        sel = 0; reset_ = 1'b0; frame = 1'b1; irdy = 1'b1; cbe = 4'h0; ad = '0;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            check("reset_ctl", {trdy_w[s], devsel_w[s], ad_oe_w[s], busy_w[s]}, 4'b1100);
            check("reset_ad_out", ad_out_w[s], 32'h0);
        end
        reset_ = 1'b1;
        step();

        for (int v = 0; v < 15; v++) begin
            if (vecs[v].claim && vecs[v].cmd == 4'b0110) sbq.push_back(vecs[v].exp_rd);
            run_cycle(0, vecs[v].addr, vecs[v].cmd, vecs[v].data, vecs[v].be, 1, -1, 0, vecs[v].claim);
        end

        // Four-beat read burst that wraps from word 15 to word 0
        for (int b = 0; b < 4; b++) sbq.push_back(model[0][(14 + b) % 16]);
        run_cycle(0, 32'h0000_1038, 4'b0110, 32'h0, 4'b0000, 4, -1, 0, 1'b1);

        // Slow target: write burst, then read burst with a two-edge master stall
        run_cycle(1, 32'h0000_1010, 4'b0111, 32'h1000_0000, 4'b0000, 4, -1, 0, 1'b1);
        for (int b = 0; b < 4; b++) sbq.push_back(model[1][4 + b]);
        run_cycle(1, 32'h0000_1010, 4'b0110, 32'h0, 4'b0000, 4, 1, 2, 1'b1);

        // Reset in the middle of a read burst
        sel = 0; frame = 1'b0; irdy = 1'b1; ad = 32'h0000_1038; cbe = 4'b0110;
        step();
        irdy = 1'b0; cbe = 4'h0; ad = '0;
        step();
        step();
        step();
        reset_ = 1'b0;
        step();
        check("rst_mid_ctl", {trdy_w[0], devsel_w[0], ad_oe_w[0], busy_w[0]}, 4'b1100);
        check("rst_mid_ad_out", ad_out_w[0], 32'h0);
        reset_ = 1'b1; frame = 1'b1; irdy = 1'b1;
        step();
        step();
        clear_models();
        for (int b = 0; b < 4; b++) sbq.push_back(model[0][(14 + b) % 16]);
        run_cycle(0, 32'h0000_1038, 4'b0110, 32'h0, 4'b0000, 4, -1, 0, 1'b1);
        sbq.push_back(model[1][5]);
        run_cycle(1, 32'h0000_1014, 4'b0110, 32'h0, 4'b0000, 1, -1, 0, 1'b1);

        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
